reg24_byte_writer: RTL and testbench



---
 rtl/reg24_byte_writer_pkg.sv | 31 +++
 rtl/reg24_byte_writer.sv | 122 ++++++++++++
 tb/tb_reg24_byte_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/reg24_byte_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg24_byte_writer_pkg
// Brief    : Shared state encoding, byte count and byte-select helper.
// Revision : 1.0
// ============================================================================
package reg24_byte_writer_pkg;

    localparam int NUM_BYTES = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Index counts transfer order; endianness maps it onto a byte lane.
    function automatic logic [7:0] byte_sel(input logic [23:0] word,
                                            input logic [1:0]  idx,
                                            input logic        little_endian);
        logic [1:0] lane;
        lane = little_endian ? idx : 2'(2'd2 - idx);
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            default: byte_sel = word[23:16];
        endcase
    endfunction

endpackage : reg24_byte_writer_pkg
`default_nettype wire

// File: rtl/reg24_byte_writer.sv
`default_nettype none
// ============================================================================
// Module   : reg24_byte_writer
// Brief    : Stores a 24-bit register value to byte-wide memory as 3 writes.
// Revision : 1.0
// ============================================================================
module reg24_byte_writer
    import reg24_byte_writer_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [23:0]       DATA_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] C_LAST_IDX = 2'(NUM_BYTES - 1);
    localparam logic       C_LE       = (LITTLE_ENDIAN != 0);

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [23:0]       r_data;
    logic [ADDR_W-1:0] r_base;

    state_t            w_state;
    logic [1:0]        w_idx;
    logic [23:0]       w_data;
    logic [ADDR_W-1:0] w_base;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_mdata;
    logic              w_busy;
    logic              w_done;
    logic [1:0]        w_idx_inc;

    assign w_idx_inc = r_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= 2'd0;
            r_data   <= 24'd0;
            r_base   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_data   <= w_data;
            r_base   <= w_base;
            mem_we   <= w_we;
            mem_addr <= w_addr;
            mem_data <= w_mdata;
            busy     <= w_busy;
            done     <= w_done;
        end
    end

    // Outputs hold by default so a stalled write keeps its address and data.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_data  = r_data;
        w_base  = r_base;
        w_we    = mem_we;
        w_addr  = mem_addr;
        w_mdata = mem_data;
        w_busy  = busy;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_we = 1'b0;
                if (start) begin
                    w_data  = DATA_IN;
                    w_base  = ADDR_IN;
                    w_idx   = 2'd0;
                    w_state = ST_WRITE;
                    w_we    = 1'b1;
                    w_addr  = ADDR_IN;
                    w_mdata = byte_sel(DATA_IN, 2'd0, C_LE);
                    w_busy  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (mem_we && mem_ready) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_we    = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_idx   = w_idx_inc;
                        w_addr  = r_base + ADDR_W'(w_idx_inc);
                        w_mdata = byte_sel(r_data, w_idx_inc, C_LE);
                    end
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
                w_we    = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

endmodule : reg24_byte_writer
`default_nettype wire

// File: tb/tb_reg24_byte_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg24_byte_writer
// Brief    : Scoreboard bench driving little- and big-endian instances together.
// Revision : 1.0
// ============================================================================
module tb_reg24_byte_writer;

    typedef struct {
        bit         is_done;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] DATA_IN = 24'd0;
    logic [7:0]  ADDR_IN = 8'd0;
    logic        mem_ready = 1'b1;

    logic       we_le, busy_le, done_le;
    logic [7:0] addr_le, data_le;
    logic       we_be, busy_be, done_be;
    logic [7:0] addr_be, data_be;

    int checks = 0;
    int failures = 0;
    exp_t q_le[$];
    exp_t q_be[$];

    always #5 clk = ~clk;

    reg24_byte_writer #(.ADDR_W(8), .LITTLE_ENDIAN(1)) u_le (
        .clk(clk), .reset(reset), .start(start), .DATA_IN(DATA_IN), .ADDR_IN(ADDR_IN),
        .mem_ready(mem_ready), .mem_we(we_le), .mem_addr(addr_le), .mem_data(data_le),
        .busy(busy_le), .done(done_le));

    reg24_byte_writer #(.ADDR_W(8), .LITTLE_ENDIAN(0)) u_be (
        .clk(clk), .reset(reset), .start(start), .DATA_IN(DATA_IN), .ADDR_IN(ADDR_IN),
        .mem_ready(mem_ready), .mem_we(we_be), .mem_addr(addr_be), .mem_data(data_be),
        .busy(busy_be), .done(done_be));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input bit le, input logic [7:0] a0, input logic [7:0] d0,
                         input logic [7:0] a1, input logic [7:0] d1,
                         input logic [7:0] a2, input logic [7:0] d2, input bit with_done);
        exp_t e;
        e.is_done = 1'b0;
        e.addr = a0; e.data = d0; if (le) q_le.push_back(e); else q_be.push_back(e);
        e.addr = a1; e.data = d1; if (le) q_le.push_back(e); else q_be.push_back(e);
        e.addr = a2; e.data = d2; if (le) q_le.push_back(e); else q_be.push_back(e);
        if (with_done) begin
            e.is_done = 1'b1; e.addr = 8'd0; e.data = 8'd0;
            if (le) q_le.push_back(e); else q_be.push_back(e);
        end
    endtask

    // Accepted writes and done pulses are sampled mid-cycle, ahead of their edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (we_le && mem_ready) begin
                if (q_le.size() == 0) check("le_unexpected_write", {addr_le, data_le}, 32'hFFFF_FFFF);
                else begin
                    e = q_le.pop_front();
                    check("le_write", {7'd0, e.is_done, addr_le, data_le}, {8'd0, e.addr, e.data});
                end
            end
            if (done_le) begin
                if (q_le.size() == 0) check("le_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q_le.pop_front();
                    check("le_done", {31'd0, e.is_done}, 32'd1);
                    check("le_busy_at_done", {31'd0, busy_le}, 32'd0);
                end
            end
            if (we_be && mem_ready) begin
                if (q_be.size() == 0) check("be_unexpected_write", {addr_be, data_be}, 32'hFFFF_FFFF);
                else begin
                    e = q_be.pop_front();
                    check("be_write", {7'd0, e.is_done, addr_be, data_be}, {8'd0, e.addr, e.data});
                end
            end
            if (done_be) begin
                if (q_be.size() == 0) check("be_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q_be.pop_front();
                    check("be_done", {31'd0, e.is_done}, 32'd1);
                    check("be_busy_at_done", {31'd0, busy_be}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [23:0] d, input logic [7:0] a);
        DATA_IN = d;
        ADDR_IN = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (!done_le && n < 50) begin
            tick();
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    task automatic drain(input string name);
        repeat (4) tick();
        check(name, q_le.size() + q_be.size(), 0);
        check({name, "_idle"}, {busy_le, busy_be, we_le, we_be}, 4'b0000);
    endtask

    initial begin
        repeat (3) tick();
        check("reset_le", {we_le, busy_le, done_le, addr_le, data_le}, 0);
        check("reset_be", {we_be, busy_be, done_be, addr_be, data_be}, 0);
        reset = 1'b0;
        tick();

        // Basic store
        push3(1, 8'h10, 8'hC3, 8'h11, 8'hB2, 8'h12, 8'hA1, 1);
        push3(0, 8'h10, 8'hA1, 8'h11, 8'hB2, 8'h12, 8'hC3, 1);
        issue(24'hA1B2C3, 8'h10);
        check("busy_after_start", {busy_le, busy_be}, 2'b11);
        wait_done("basic_latency", 3);
        tick();
        check("basic_done_one_cycle", {done_le, done_be, busy_le}, 3'b000);
        drain("basic");

        // Back-pressure on byte 1
        push3(1, 8'h10, 8'hC3, 8'h11, 8'hB2, 8'h12, 8'hA1, 1);
        push3(0, 8'h10, 8'hA1, 8'h11, 8'hB2, 8'h12, 8'hC3, 1);
        issue(24'hA1B2C3, 8'h10);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_le", {we_le, addr_le, data_le}, {1'b1, 8'h11, 8'hB2});
            check("stall_be", {we_be, addr_be, data_be}, {1'b1, 8'h11, 8'hB2});
        end
        mem_ready = 1'b1;
        wait_done("stall_latency", 2);
        drain("stall");

        // Address wrap, both byte orders
        push3(1, 8'hFF, 8'h56, 8'h00, 8'h34, 8'h01, 8'h12, 1);
        push3(0, 8'hFF, 8'h12, 8'h00, 8'h34, 8'h01, 8'h56, 1);
        issue(24'h123456, 8'hFF);
        wait_done("wrap_latency", 3);
        drain("wrap");

        // start held through WRITE and DONE must be ignored
        push3(1, 8'h20, 8'h33, 8'h21, 8'h22, 8'h22, 8'h11, 1);
        push3(0, 8'h20, 8'h11, 8'h21, 8'h22, 8'h22, 8'h33, 1);
        issue(24'h112233, 8'h20);
        DATA_IN = 24'hFFFFFF;
        ADDR_IN = 8'h80;
        start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        drain("ignored_start");

        // Reset after byte 0 accepted
        begin
            exp_t e;
            e.is_done = 1'b0;
            e.addr = 8'h40; e.data = 8'hCC; q_le.push_back(e);
            e.addr = 8'h40; e.data = 8'hAA; q_be.push_back(e);
        end
        issue(24'hAABBCC, 8'h40);
        tick();
        reset = 1'b1;
        tick();
        check("midreset_le", {we_le, busy_le, done_le}, 3'b000);
        check("midreset_be", {we_be, busy_be, done_be}, 3'b000);
        reset = 1'b0;
        drain("midreset");
        push3(1, 8'h50, 8'h03, 8'h51, 8'h02, 8'h52, 8'h01, 1);
        push3(0, 8'h50, 8'h01, 8'h51, 8'h02, 8'h52, 8'h03, 1);
        issue(24'h010203, 8'h50);
        wait_done("fresh_latency", 3);
        drain("fresh");

        // Idle quiet
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_quiet", {we_le, busy_le, done_le, we_be, busy_be, done_be}, 6'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg24_byte_writer
`default_nettype wire
